interface_alu_uart: RTL and testbench

INTERFACE_ALU_UART -- requirements
Module: interface_alu_uart

---
 rtl/interface_alu_uart.sv | 160 ++++++++++++++++
 tb/tb_interface_alu_uart.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/interface_alu_uart.sv
// Frames an ALU result (and optionally a status word) for a UART transmitter.
// Optional macro STATUS_FRAME_EN adds a status frame after every result frame.
module interface_alu_uart #(
   parameter int NB_DATA      = 8,
   parameter int NB_FULL_DATA = 10
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [NB_DATA-1:0]      i_result,
   input  logic                    i_carry,
   input  logic                    i_result_valid,
   input  logic                    i_tx_busy,
   input  logic                    i_tx_done,
   output logic [NB_FULL_DATA-1:0] o_tx_data,
   output logic                    o_tx_start,
   output logic                    o_busy,
   output logic                    o_overrun
);

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] HOLD      = 2'd1;
   localparam logic [1:0] START     = 2'd2;
   localparam logic [1:0] WAIT_DONE = 2'd3;

   logic [1:0]              state_r;
   logic [1:0]              state_next_s;
   logic [NB_DATA-1:0]      result_r;
   logic [NB_DATA-1:0]      result_next_s;
   logic                    carry_r;
   logic                    carry_next_s;
   logic                    zero_r;
   logic                    zero_next_s;
   logic                    neg_r;
   logic                    neg_next_s;
   logic                    overrun_r;
   logic                    overrun_next_s;
   logic                    tx_start_r;
   logic [NB_FULL_DATA-1:0] tx_data_r;
   logic [NB_FULL_DATA-1:0] frame_data_s;

`ifdef STATUS_FRAME_EN
   logic                    frame_r;
   logic                    frame_next_s;
   logic [NB_FULL_DATA-1:0] status_s;
`else
   logic                    unused_flags_s;
   assign unused_flags_s = ^{carry_r, zero_r, neg_r};
`endif

   // Next-state, capture and overrun logic
   always_comb begin
      state_next_s   = state_r;
      result_next_s  = result_r;
      carry_next_s   = carry_r;
      zero_next_s    = zero_r;
      neg_next_s     = neg_r;
      overrun_next_s = overrun_r | (i_result_valid & (state_r != IDLE));
`ifdef STATUS_FRAME_EN
      frame_next_s   = frame_r;
`endif
      case (state_r)
         IDLE: begin
            if (i_result_valid) begin
               result_next_s = i_result;
               carry_next_s  = i_carry;
               zero_next_s   = (i_result == '0);
               neg_next_s    = i_result[NB_DATA-1];
`ifdef STATUS_FRAME_EN
               frame_next_s  = 1'b0;
`endif
               if (i_tx_busy) begin
                  state_next_s = HOLD;
               end else begin
                  state_next_s = START;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         HOLD: begin
            if (!i_tx_busy) begin
               state_next_s = START;
            end else begin
               state_next_s = HOLD;
            end
         end
         START: state_next_s = WAIT_DONE;
         WAIT_DONE: begin
            if (i_tx_done) begin
`ifdef STATUS_FRAME_EN
               if (!frame_r) begin
                  state_next_s = START;
                  frame_next_s = 1'b1;
               end else begin
                  state_next_s = IDLE;
                  frame_next_s = 1'b0;
               end
`else
               state_next_s = IDLE;
`endif
            end else begin
               state_next_s = WAIT_DONE;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Frame selection; status word uses the flag values being registered this cycle
   always_comb begin
      frame_data_s = {2'b11, result_next_s};
`ifdef STATUS_FRAME_EN
      status_s = '0;
      status_s[NB_FULL_DATA-1 -: 2] = 2'b10;
      status_s[3:0] = {overrun_next_s, neg_next_s, zero_next_s, carry_next_s};
      if (frame_next_s) begin
         frame_data_s = status_s;
      end else begin
         frame_data_s = {2'b11, result_next_s};
      end
`endif
   end

   // State and output registers; tx data is only reloaded on entry to START
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_r    <= IDLE;
         result_r   <= '0;
         carry_r    <= 1'b0;
         zero_r     <= 1'b0;
         neg_r      <= 1'b0;
         overrun_r  <= 1'b0;
         tx_start_r <= 1'b0;
         tx_data_r  <= '0;
`ifdef STATUS_FRAME_EN
         frame_r    <= 1'b0;
`endif
      end else begin
         state_r    <= state_next_s;
         result_r   <= result_next_s;
         carry_r    <= carry_next_s;
         zero_r     <= zero_next_s;
         neg_r      <= neg_next_s;
         overrun_r  <= overrun_next_s;
         tx_start_r <= (state_next_s == START);
         if (state_next_s == START) begin
            tx_data_r <= frame_data_s;
         end
`ifdef STATUS_FRAME_EN
         frame_r    <= frame_next_s;
`endif
      end
   end

   assign o_busy     = (state_r != IDLE);
   assign o_tx_start = tx_start_r;
   assign o_tx_data  = tx_data_r;
   assign o_overrun  = overrun_r;

endmodule

// File: tb/tb_interface_alu_uart.sv
// Directed self-checking bench for interface_alu_uart; expectations follow
// whether STATUS_FRAME_EN is defined for the build.
module tb_interface_alu_uart;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_result;
   logic       i_carry;
   logic       i_result_valid;
   logic       i_tx_busy;
   logic       i_tx_done;
   logic [9:0] o_tx_data;
   logic       o_tx_start;
   logic       o_busy;
   logic       o_overrun;

   int total = 0;
   int bad   = 0;

   interface_alu_uart #(.NB_DATA(8), .NB_FULL_DATA(10)) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_result       (i_result),
      .i_carry        (i_carry),
      .i_result_valid (i_result_valid),
      .i_tx_busy      (i_tx_busy),
      .i_tx_done      (i_tx_done),
      .o_tx_data      (o_tx_data),
      .o_tx_start     (o_tx_start),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic done_pulse();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
   endtask

   // Valid pulse with tx idle: expect start on the next cycle carrying exp_frame
   task automatic accept(input string tag, input logic [7:0] res, input logic c,
                         input logic [9:0] exp_frame);
      i_result = res;
      i_carry = c;
      i_result_valid = 1'b1;
      tick();
      i_result_valid = 1'b0;
      chk({tag, "_start"}, 16'(o_tx_start), 16'd1);
      chk({tag, "_data"}, 16'(o_tx_data), 16'(exp_frame));
      chk({tag, "_busy"}, 16'(o_busy), 16'd1);
      tick();
      chk({tag, "_start_one_cycle"}, 16'(o_tx_start), 16'd0);
      chk({tag, "_data_held"}, 16'(o_tx_data), 16'(exp_frame));
   endtask

   // Status pass (only when built); ends back in IDLE
   task automatic finish(input string tag, input logic [9:0] exp_status, input logic [9:0] exp_last);
`ifdef STATUS_FRAME_EN
      done_pulse();
      chk({tag, "_st_start"}, 16'(o_tx_start), 16'd1);
      chk({tag, "_st_data"}, 16'(o_tx_data), 16'(exp_status));
      tick();
      chk({tag, "_st_one_cycle"}, 16'(o_tx_start), 16'd0);
      done_pulse();
      chk({tag, "_idle"}, 16'(o_busy), 16'd0);
      chk({tag, "_last_data"}, 16'(o_tx_data), 16'(exp_status));
`else
      done_pulse();
      chk({tag, "_idle"}, 16'(o_busy), 16'd0);
      chk({tag, "_last_data"}, 16'(o_tx_data), 16'(exp_last));
`endif
      chk({tag, "_no_start"}, 16'(o_tx_start), 16'd0);
      tick();
      chk({tag, "_no_second"}, 16'(o_tx_start), 16'd0);
   endtask

   initial begin
      i_reset = 1'b0;
      i_result = 8'h00;
      i_carry = 1'b0;
      i_result_valid = 1'b0;
      i_tx_busy = 1'b0;
      i_tx_done = 1'b0;
      tick();
      tick();
      chk("rst_start", 16'(o_tx_start), 16'd0);
      chk("rst_data", 16'(o_tx_data), 16'd0);
      chk("rst_busy", 16'(o_busy), 16'd0);
      chk("rst_overrun", 16'(o_overrun), 16'd0);
      i_reset = 1'b1;
      tick();

      // Plain result, negative flag set
      accept("a5", 8'hA5, 1'b0, 10'h3A5);
      finish("a5", 10'h204, 10'h3A5);

      // Zero result with carry
      accept("z0", 8'h00, 1'b1, 10'h300);
      finish("z0", 10'h203, 10'h300);

      // Transmitter busy at capture: HOLD until busy falls
      i_tx_busy = 1'b1;
      i_result = 8'h3C;
      i_carry = 1'b0;
      i_result_valid = 1'b1;
      tick();
      i_result_valid = 1'b0;
      chk("hold_start", 16'(o_tx_start), 16'd0);
      chk("hold_busy", 16'(o_busy), 16'd1);
      tick();
      chk("hold_start2", 16'(o_tx_start), 16'd0);
      i_tx_busy = 1'b0;
      tick();
      chk("hold_rel_start", 16'(o_tx_start), 16'd1);
      chk("hold_rel_data", 16'(o_tx_data), 16'h33C);
      i_tx_busy = 1'b1;
      tick();
      chk("hold_wait_start", 16'(o_tx_start), 16'd0);
      finish("hold", 10'h200, 10'h33C);
      i_tx_busy = 1'b0;
      tick();

      // Overrun: second valid during WAIT_DONE is dropped
      accept("ov", 8'h80, 1'b0, 10'h380);
      i_result = 8'h11;
      i_result_valid = 1'b1;
      tick();
      i_result_valid = 1'b0;
      chk("ov_flag", 16'(o_overrun), 16'd1);
      chk("ov_data_kept", 16'(o_tx_data), 16'h380);
      chk("ov_no_start", 16'(o_tx_start), 16'd0);
      finish("ov", 10'h20A, 10'h380);
      chk("ov_sticky", 16'(o_overrun), 16'd1);

      // Reset mid-frame aborts and clears everything
      accept("rm", 8'h55, 1'b0, 10'h355);
      i_reset = 1'b0;
      tick();
      i_reset = 1'b1;
      chk("rm_busy", 16'(o_busy), 16'd0);
      chk("rm_overrun", 16'(o_overrun), 16'd0);
      chk("rm_data", 16'(o_tx_data), 16'd0);
      chk("rm_start", 16'(o_tx_start), 16'd0);
      tick();
      chk("rm_start_after", 16'(o_tx_start), 16'd0);
      chk("rm_busy_after", 16'(o_busy), 16'd0);

      // New valid after reset; another valid coincides with the final done
      accept("fd", 8'h01, 1'b0, 10'h301);
`ifdef STATUS_FRAME_EN
      done_pulse();
      chk("fd_st_data", 16'(o_tx_data), 16'h200);
      tick();
`endif
      i_tx_done = 1'b1;
      i_result = 8'h77;
      i_result_valid = 1'b1;
      tick();
      i_tx_done = 1'b0;
      i_result_valid = 1'b0;
      chk("fd_idle", 16'(o_busy), 16'd0);
      chk("fd_overrun", 16'(o_overrun), 16'd1);
      chk("fd_start", 16'(o_tx_start), 16'd0);
      tick();
      chk("fd_dropped_start", 16'(o_tx_start), 16'd0);
      chk("fd_dropped_busy", 16'(o_busy), 16'd0);

      // Stray done in IDLE is ignored
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      chk("stray_busy", 16'(o_busy), 16'd0);
      chk("stray_start", 16'(o_tx_start), 16'd0);
      tick();
      chk("stray_start2", 16'(o_tx_start), 16'd0);
      chk("stray_overrun", 16'(o_overrun), 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
